// File: rtl/dmem_if.sv
// Core-side load/store port: one request channel and one response channel,
// each with its own valid/ready handshake.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_access_size;
  logic        req_unsigned;
  logic        req_rw;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_wdata, req_access_size, req_unsigned, req_rw, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_access_size, req_unsigned, req_rw, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed latency,
// little-endian byte/half/word stores, extended loads, fault flagging.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic  clock,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int unsigned IDXW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rw_q, rw_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With LATENCY==1 the accept edge is also the commit/read edge, so the
  // decode looks at the live request while idle and the latched one otherwise.
  logic        idle;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size;
  logic        c_uns, c_rw;
  logic [31:0] off;
  logic [IDXW-1:0] idx;
  logic [1:0]  lane;
  logic        out_rng, bad;
  logic [31:0] rword, ld, wsh;
  logic [15:0] rsh;
  logic [3:0]  be;
  logic        enter_resp, commit;

  assign idle    = (state_q == IDLE);
  assign c_addr  = idle ? bus.req_addr        : addr_q;
  assign c_wdata = idle ? bus.req_wdata       : wdata_q;
  assign c_size  = idle ? bus.req_access_size : size_q;
  assign c_uns   = idle ? bus.req_unsigned    : uns_q;
  assign c_rw    = idle ? bus.req_rw          : rw_q;

  assign off     = c_addr - BASE_ADDR;
  assign idx     = IDXW'(off >> 2);
  assign lane    = c_addr[1:0];
  assign out_rng = ({1'b0, c_addr} < {1'b0, BASE_ADDR}) || ({1'b0, c_addr} >= END_ADDR);

  always_comb begin
    bad = out_rng;
    case (c_size)
      2'b01:   if (c_addr[0])          bad = 1'b1;
      2'b10:   if (c_addr[1:0] != 2'd0) bad = 1'b1;
      2'b11:   bad = 1'b1;
      default: ;
    endcase
  end

  assign rword = mem_q[idx];
  assign rsh   = 16'(rword >> {lane, 3'b000});
  assign wsh   = c_wdata << {lane, 3'b000};

  always_comb begin
    case (c_size)
      2'b00:   ld = {{24{~c_uns & rsh[7]}},  rsh[7:0]};
      2'b01:   ld = {{16{~c_uns & rsh[15]}}, rsh[15:0]};
      default: ld = rword;
    endcase
  end

  always_comb begin
    case (c_size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        size_d  = bus.req_access_size;
        uns_d   = bus.req_unsigned;
        rw_d    = bus.req_rw;
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rdata_d = (c_rw || bad) ? 32'h0 : ld;
      err_d   = bad;
    end
  end

  assign enter_resp = (state_q != RESP) && (state_d == RESP);
  assign commit     = reset && enter_resp && c_rw && !bad;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rw_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; only the lanes selected by be are written.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end

  assign bus.req_ready = reset && idle;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=4 instance.
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clock = 1'b0;
  logic rst2_n, rst4_n;
  int   pass = 0, tot = 0;

  always #5 clock = ~clock;

  dmem_if b2();
  dmem_if b4();

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(2)) u2 (
    .clock(clock), .reset(rst2_n), .bus(b2));
  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(4)) u4 (
    .clock(clock), .reset(rst4_n), .bus(b4));

  task automatic set_req(input logic sel, input logic v, input logic rw, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      b4.req_valid = v; b4.req_rw = rw; b4.req_access_size = sz;
      b4.req_unsigned = uns; b4.req_addr = a; b4.req_wdata = wd;
    end else begin
      b2.req_valid = v; b2.req_rw = rw; b2.req_access_size = sz;
      b2.req_unsigned = uns; b2.req_addr = a; b2.req_wdata = wd;
    end
  endtask

  // One full transaction with rsp_ready held high; lat counts edges from accept to rsp_valid.
  task automatic xact(input logic sel, input logic rw, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    set_req(sel, 1'b1, rw, sz, uns, a, wd);
    n = 0;
    while (!(sel ? b4.req_ready : b2.req_ready) && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    set_req(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    lat = 0;
    while (!(sel ? b4.rsp_valid : b2.rsp_valid) && lat < 50) begin @(posedge clock); #1; lat++; end
    rd = sel ? b4.rsp_rdata : b2.rsp_rdata;
    er = sel ? b4.rsp_error : b2.rsp_error;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    rst2_n = 1'b0; rst4_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    b2.rsp_ready = 1'b1; b4.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tot++; if (b2.req_ready !== 1'b0) $display("FAIL rst_ready2 got %b exp 0", b2.req_ready); else pass++;
    tot++; if (b4.req_ready !== 1'b0) $display("FAIL rst_ready4 got %b exp 0", b4.req_ready); else pass++;
    tot++; if ({b2.rsp_valid, b2.rsp_error, b2.rsp_rdata} !== 34'h0)
      $display("FAIL rst_rsp2 got v=%b e=%b d=%h exp all 0", b2.rsp_valid, b2.rsp_error, b2.rsp_rdata); else pass++;
    tot++; if ({b4.rsp_valid, b4.rsp_error, b4.rsp_rdata} !== 34'h0)
      $display("FAIL rst_rsp4 got v=%b e=%b d=%h exp all 0", b4.rsp_valid, b4.rsp_error, b4.rsp_rdata); else pass++;
    rst2_n = 1'b1; rst4_n = 1'b1;
    @(posedge clock); #1;
    tot++; if (b2.req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", b2.req_ready); else pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 1'b1, 2'b10, 1'b0, BASE, 32'hDEADBEEF, rd, er, lat);
    tot++; if (er !== 1'b0 || rd !== 32'h0) $display("FAIL st_word got e=%b d=%h exp e=0 d=0", er, rd); else pass++;
    tot++; if (lat !== 2) $display("FAIL st_word_lat got %0d exp 2", lat); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er, lat);
    tot++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) $display("FAIL ld_word got e=%b d=%h exp e=0 d=deadbeef", er, rd); else pass++;
    tot++; if (lat !== 2) $display("FAIL ld_word_lat got %0d exp 2", lat); else pass++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 1'b1, 2'b00, 1'b0, BASE + 32'd3, 32'hAAAAAA80, rd, er, lat);
    tot++; if (er !== 1'b0) $display("FAIL st_byte_err got %b exp 0", er); else pass++;
    xact(1'b0, 1'b0, 2'b00, 1'b0, BASE + 32'd3, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'hFFFFFF80) $display("FAIL ld_byte_s got %h exp ffffff80", rd); else pass++;
    xact(1'b0, 1'b0, 2'b00, 1'b1, BASE + 32'd3, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h00000080) $display("FAIL ld_byte_u got %h exp 00000080", rd); else pass++;
    xact(1'b0, 1'b0, 2'b00, 1'b0, BASE + 32'd1, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'hFFFFFFBE) $display("FAIL ld_byte_l1 got %h exp ffffffbe", rd); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b1, BASE, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h80ADBEEF) $display("FAIL ld_word_after_byte got %h exp 80adbeef", rd); else pass++;
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 1'b0, 2'b01, 1'b0, BASE + 32'd2, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'hFFFF80AD || er !== 1'b0) $display("FAIL ld_half_s got e=%b d=%h exp e=0 d=ffff80ad", er, rd); else pass++;
    xact(1'b0, 1'b0, 2'b01, 1'b1, BASE + 32'd2, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h000080AD) $display("FAIL ld_half_u got %h exp 000080ad", rd); else pass++;
    xact(1'b0, 1'b1, 2'b01, 1'b0, BASE + 32'd1, 32'h00001234, rd, er, lat);
    tot++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL st_half_misal got e=%b d=%h exp e=1 d=0", er, rd); else pass++;
    tot++; if (lat !== 2) $display("FAIL st_half_misal_lat got %0d exp 2", lat); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h80ADBEEF) $display("FAIL ld_word_after_misal got %h exp 80adbeef", rd); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, BASE + 32'd2, 32'h0, rd, er, lat);
    tot++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL ld_word_misal got e=%b d=%h exp e=1 d=0", er, rd); else pass++;
  endtask

  task automatic test_backpressure();
    int lat, badc;
    b2.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
    @(posedge clock); #1;
    set_req(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, BASE + 32'd3, 32'h0);
    lat = 0;
    while (!b2.rsp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
    tot++; if (lat !== 2) $display("FAIL bp_lat got %0d exp 2", lat); else pass++;
    badc = 0;
    repeat (5) begin
      if (b2.rsp_valid !== 1'b1 || b2.rsp_rdata !== 32'h80ADBEEF || b2.rsp_error !== 1'b0 || b2.req_ready !== 1'b0) badc++;
      @(posedge clock); #1;
    end
    tot++; if (badc !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", badc); else pass++;
    tot++; if (b2.rsp_valid !== 1'b1 || b2.rsp_rdata !== 32'h80ADBEEF)
      $display("FAIL bp_still got v=%b d=%h exp v=1 d=80adbeef", b2.rsp_valid, b2.rsp_rdata); else pass++;
    b2.rsp_ready = 1'b1;
    @(posedge clock); #1;
    tot++; if (b2.rsp_valid !== 1'b0 || b2.req_ready !== 1'b1)
      $display("FAIL bp_after_hs got v=%b rdy=%b exp v=0 rdy=1", b2.rsp_valid, b2.req_ready); else pass++;
    @(posedge clock); #1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    tot++; if (b2.req_ready !== 1'b0 || b2.rsp_valid !== 1'b0)
      $display("FAIL bp_accept2 got rdy=%b v=%b exp rdy=0 v=0", b2.req_ready, b2.rsp_valid); else pass++;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tot++; if (b2.rsp_valid !== 1'b1 || b2.rsp_rdata !== 32'h00000080)
      $display("FAIL bp_second got v=%b d=%h exp v=1 d=00000080", b2.rsp_valid, b2.rsp_rdata); else pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 1'b1, 2'b10, 1'b0, BASE + 32'h0FFC, 32'h5A5A5A5A, rd, er, lat);
    tot++; if (er !== 1'b0) $display("FAIL st_last_word got e=%b exp 0", er); else pass++;
    xact(1'b0, 1'b1, 2'b10, 1'b0, BASE + 32'h1000, 32'h11111111, rd, er, lat);
    tot++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2)
      $display("FAIL st_past_end got e=%b d=%h lat=%0d exp e=1 d=0 lat=2", er, rd, lat); else pass++;
    xact(1'b0, 1'b1, 2'b11, 1'b0, BASE, 32'hFFFFFFFF, rd, er, lat);
    tot++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL st_size11 got e=%b d=%h exp e=1 d=0", er, rd); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, 32'h00FFFFFC, 32'h0, rd, er, lat);
    tot++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL ld_below_base got e=%b d=%h exp e=1 d=0", er, rd); else pass++;
    xact(1'b0, 1'b1, 2'b10, 1'b0, 32'h00FFFFFC, 32'h22222222, rd, er, lat);
    tot++; if (er !== 1'b1) $display("FAIL st_below_base got e=%b exp 1", er); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h80ADBEEF || er !== 1'b0) $display("FAIL err_mem_w0 got e=%b d=%h exp e=0 d=80adbeef", er, rd); else pass++;
    xact(1'b0, 1'b0, 2'b10, 1'b0, BASE + 32'h0FFC, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'h5A5A5A5A || er !== 1'b0) $display("FAIL err_mem_last got e=%b d=%h exp e=0 d=5a5a5a5a", er, rd); else pass++;
  endtask

  task automatic test_lat4_reset();
    logic [31:0] rd; logic er; int lat, badc;
    xact(1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'hCAFEF00D, rd, er, lat);
    tot++; if (lat !== 4 || er !== 1'b0) $display("FAIL l4_st_lat got lat=%0d e=%b exp lat=4 e=0", lat, er); else pass++;
    set_req(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, BASE + 32'h10, 32'h12345678);
    @(posedge clock); #1;
    set_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    tot++; if (b4.req_ready !== 1'b0) $display("FAIL l4_accepted got rdy=%b exp 0", b4.req_ready); else pass++;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst4_n = 1'b0;
    badc = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (b4.rsp_valid !== 1'b0 || b4.req_ready !== 1'b0) badc++;
    end
    tot++; if (badc !== 0) $display("FAIL l4_in_reset got %0d bad cycles exp 0", badc); else pass++;
    rst4_n = 1'b1;
    #1;
    tot++; if (b4.req_ready !== 1'b1) $display("FAIL l4_release_ready got %b exp 1", b4.req_ready); else pass++;
    badc = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (b4.rsp_valid !== 1'b0) badc++;
    end
    tot++; if (badc !== 0) $display("FAIL l4_no_rsp got %0d cycles with rsp_valid exp 0", badc); else pass++;
    xact(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, rd, er, lat);
    tot++; if (rd !== 32'hCAFEF00D || er !== 1'b0) $display("FAIL l4_ld_prior got e=%b d=%h exp e=0 d=cafef00d", er, rd); else pass++;
    tot++; if (lat !== 4) $display("FAIL l4_ld_lat got %0d exp 4", lat); else pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_errors();
    test_lat4_reset();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
